// File: rtl/pixel_uart_pkg.sv
// Shared types and constants for the pixel UART framer and its byte engine.
// PIXEL_UART_CHECKSUM_EN adds the CSUM framer state (trailing checksum byte).
package pixel_uart_pkg;

   localparam int UART_BITS = 10;
   localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

   typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} byte_state_t;

`ifdef PIXEL_UART_CHECKSUM_EN
   typedef enum logic [1:0] {IDLE, SYNC, DATA, CSUM} framer_state_t;
`else
   typedef enum logic [1:0] {IDLE, SYNC, DATA} framer_state_t;
`endif

endpackage

// File: rtl/pixel_uart_tx_if.sv
// Pixel stream into the UART framer (AXI-Stream subset: valid/ready/data/last).
interface pixel_uart_tx_if;

   // A beat transfers on a clock edge where s_tvalid && s_tready; the master holds
   // data/last stable while valid is high and ready is low.
   logic       s_tvalid;
   logic       s_tready;
   logic [7:0] s_tdata;
   logic       s_tlast;

   modport master (output s_tvalid, s_tdata, s_tlast, input s_tready);
   modport slave  (input s_tvalid, s_tdata, s_tlast, output s_tready);

endinterface

// File: rtl/uart_byte_tx.sv
// 8N1 byte serialiser: start bit, 8 data bits LSB first, stop bit, CLK_DIV clocks each.
// done marks the last stop-bit cycle; the next load is taken in the following idle cycle.
module uart_byte_tx
   import pixel_uart_pkg::*;
#(
   parameter int CLK_DIV = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       load,
   input  logic [7:0] data,
   output logic       tx,
   output logic       done,
   output logic       idle
);

   localparam int CW        = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int DATA_BITS = UART_BITS - 2;

   byte_state_t   state, state_nx;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          bit_end;

   assign bit_end = (baud_cnt == CW'(CLK_DIV - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= B_IDLE;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else begin
         state <= state_nx;
         if (state == B_IDLE) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            if (load) shreg <= data;
         end else if (bit_end) begin
            baud_cnt <= '0;
            if (state == B_DATA) begin
               shreg   <= {1'b0, shreg[7:1]};
               bit_idx <= bit_idx + 3'd1;
            end
         end else begin
            baud_cnt <= baud_cnt + CW'(1);
         end
      end
   end

   always_comb begin
      state_nx = state;
      tx       = 1'b1;
      done     = 1'b0;
      idle     = 1'b0;
      case (state)
         B_IDLE: begin
            idle = 1'b1;
            if (load) state_nx = B_START;
         end
         B_START: begin
            tx = 1'b0;
            if (bit_end) state_nx = B_DATA;
         end
         B_DATA: begin
            tx = shreg[0];
            if (bit_end && bit_idx == 3'(DATA_BITS - 1)) state_nx = B_STOP;
         end
         B_STOP: begin
            if (bit_end) begin
               done     = 1'b1;
               state_nx = B_IDLE;
            end
         end
         default: state_nx = B_IDLE;
      endcase
   end

endmodule

// File: rtl/pixel_uart_tx.sv
// Pixel stream to UART: FIFO, then frames of SYNC byte + pixels (+ checksum byte
// when PIXEL_UART_CHECKSUM_EN is defined), serialised by uart_byte_tx.
module pixel_uart_tx
   import pixel_uart_pkg::*;
#(
   parameter int         CLK_DIV    = 16,
   parameter int         FIFO_DEPTH = 4,
   parameter logic [7:0] SYNC_BYTE  = DEFAULT_SYNC_BYTE
) (
   input  logic              clk,
   input  logic              rst,
   pixel_uart_tx_if.slave    s_axis,
   output logic              uart_tx,
   output logic              busy,
   output logic              frame_done,
   output logic [15:0]       frame_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);

   logic [8:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          full, empty, push, pop;
   logic [8:0]    head;

   framer_state_t state, state_nx;
   logic          last_flag;
   logic          frame_end;
   logic          eng_load, eng_done, eng_idle;
   logic [7:0]    byte_data;
`ifdef PIXEL_UART_CHECKSUM_EN
   logic [7:0]    checksum;
`endif

   // Ready comes from the registered count only, so a pop while full frees a slot next cycle.
   assign full            = (count == (AW+1)'(FIFO_DEPTH));
   assign empty           = (count == '0);
   assign s_axis.s_tready = !rst && !full;
   assign push            = s_axis.s_tvalid && s_axis.s_tready;
   assign head            = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= {s_axis.s_tlast, s_axis.s_tdata};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW+1)'(1);
            2'b01:   count <= count - (AW+1)'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         last_flag  <= 1'b0;
         frame_done <= 1'b0;
         frame_cnt  <= '0;
`ifdef PIXEL_UART_CHECKSUM_EN
         checksum   <= '0;
`endif
      end else begin
         state      <= state_nx;
         frame_done <= frame_end;
         if (frame_end) frame_cnt <= frame_cnt + 16'd1;
         if (pop) last_flag <= head[8];
         else if (state == DATA && eng_done) last_flag <= 1'b0;
`ifdef PIXEL_UART_CHECKSUM_EN
         if (state == IDLE && eng_load) checksum <= '0;
         else if (pop) checksum <= checksum + head[7:0];
`endif
      end
   end

   // A tlast pixel closes the frame even when later pixels already sit in the FIFO.
   always_comb begin
      state_nx  = state;
      eng_load  = 1'b0;
      byte_data = SYNC_BYTE;
      pop       = 1'b0;
      frame_end = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && eng_idle) begin
               eng_load = 1'b1;
               state_nx = SYNC;
            end
         end
         SYNC: begin
            if (eng_done) state_nx = DATA;
         end
         DATA: begin
            if (eng_idle && !empty) begin
               pop       = 1'b1;
               eng_load  = 1'b1;
               byte_data = head[7:0];
            end else if (eng_done && last_flag) begin
`ifdef PIXEL_UART_CHECKSUM_EN
               state_nx  = CSUM;
`else
               state_nx  = IDLE;
               frame_end = 1'b1;
`endif
            end
         end
`ifdef PIXEL_UART_CHECKSUM_EN
         CSUM: begin
            if (eng_idle) begin
               eng_load  = 1'b1;
               byte_data = checksum;
            end else if (eng_done) begin
               state_nx  = IDLE;
               frame_end = 1'b1;
            end
         end
`endif
         default: state_nx = IDLE;
      endcase
   end

   assign busy = (state != IDLE) || !empty;

   uart_byte_tx #(.CLK_DIV(CLK_DIV)) u_byte (
      .clk  (clk),
      .rst  (rst),
      .load (eng_load),
      .data (byte_data),
      .tx   (uart_tx),
      .done (eng_done),
      .idle (eng_idle)
   );

endmodule

// File: doc/pixel_uart_tx.md
Name: pixel_uart_tx

Overview:
- Downstream consumer of the pixel-array controller's AXI-Stream output: 8-bit pixels, with tlast on the final pixel of each frame.
- Buffers incoming pixels in a small FIFO and frames each image as SYNC byte, pixel bytes, then an optional checksum byte.
- Serialises the frame over a single UART TX line (8N1, LSB first) to the off-chip host.

Parameters:
- CLK_DIV, 16, clk cycles per UART bit; legal range ≥2.
- FIFO_DEPTH, 4, FIFO entries; power of two, ≥2.
- SYNC_BYTE, 8'hA5, frame start marker sent before the first pixel of every frame.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- s_tvalid  in  1  AXIS slave valid
- s_tready  out  1  AXIS slave ready
- s_tdata  in  8  pixel value
- s_tlast  in  1  last pixel of frame
- uart_tx  out  1  serial line; idle high
- busy  out  1  high while the framer is not in IDLE or the FIFO is non-empty
- frame_done  out  1  one-cycle pulse at end of frame
- frame_cnt  out  16  completed-frame counter

Behaviour:
- Reset: rst is synchronous, active-high; clock is clk. Reset outputs:
  - uart_tx=1, s_tready=0 during reset, busy=0, frame_done=0, frame_cnt=0.
  - FIFO emptied, checksum cleared, framer in IDLE, byte engine idle.
- Reset mid-byte aborts the transmission; the line returns high the cycle after rst is sampled.
- FIFO:
  - Stores {tlast, tdata}.
  - s_tready = !full, derived from the registered count only.
  - Push occurs when s_tvalid && s_tready.
  - When full, a same-cycle pop does not enable a push; s_tready rises the following cycle.
  - Push and pop in the same cycle while non-full leaves the count unchanged.
  - Pop only when the framer is in DATA and the byte engine is idle.
- Byte engine (sub-module):
  - States B_IDLE, B_START, B_DATA, B_STOP.
  - Load in cycle N: uart_tx=0 for cycles N+1..N+CLK_DIV.
  - Then 8 data bits LSB first, CLK_DIV cycles each.
  - Then stop bit high for CLK_DIV cycles.
  - Reports done in the last stop-bit cycle; a byte occupies exactly 10*CLK_DIV cycles.
  - A new load is accepted the cycle after done, so back-to-back bytes have no extra idle bit.
- Framer states: IDLE, SYNC, DATA, CSUM.
  - IDLE: FIFO non-empty -> load SYNC_BYTE, clear checksum, go to SYNC.
  - SYNC: on byte done -> DATA.
  - DATA: when byte engine idle and FIFO non-empty, pop and load the pixel; checksum += pixel (mod 256, 8-bit wrap).
  - If the popped entry has tlast=1, the next state after that byte's done is CSUM (feature on) or IDLE (feature off).
  - DATA with an empty FIFO: wait indefinitely; the line stays high and no timeout applies.
  - CSUM: load the checksum; on done -> IDLE.
- End of frame: frame_done pulses for one cycle in the cycle after the final byte's done. frame_cnt increments in the same cycle and wraps 0xFFFF->0x0000.
- Frame boundary:
  - A tlast-marked byte closes the frame even if further pixels are already queued.
  - The next frame starts with a new SYNC_BYTE.
- Zero-length frames are impossible, since every frame contains at least its tlast pixel.

Optional Feature:
- PIXEL_UART_CHECKSUM_EN defined: a CSUM byte (8-bit modular sum of the frame's pixel bytes, SYNC excluded) is sent after the tlast pixel.
- Undefined: no checksum register or CSUM state; the frame ends after the tlast pixel's stop bit.

Decomposition:
- Shared package pixel_uart_pkg holds:
  - framer state enum (IDLE/SYNC/DATA/CSUM),
  - byte engine state enum,
  - UART_BITS=10 constant,
  - default SYNC_BYTE constant.
- Sub-module uart_byte_tx: the byte engine, with ports clk, rst, load, data[7:0], tx, done, idle.
- FIFO is inline.

Test Plan:
- Single frame, CLK_DIV=4, pixels 0x00..0x0F, tlast on 0x0F, checksum on -> line decodes A5,00..0F,78; frame_done one pulse; frame_cnt=1; total 18*40=720 bit-cycles.
- Backpressure, FIFO_DEPTH=4, s_tvalid held high during the SYNC byte -> exactly 4 pushes then s_tready=0; each pop re-enables ready one cycle later; no data lost or duplicated.
- Two back-to-back 4-pixel frames {FF,FF,FF,FF}, {01,02,03,04} -> A5,FF,FF,FF,FF,FC,A5,01,02,03,04,0A; frame_cnt=2.
- Reset asserted mid-data-bit of the third byte -> uart_tx=1 next cycle; FIFO empty; frame_cnt=0; a fresh frame afterwards starts with A5.
- Checksum off, 16-pixel frame -> 17 bytes, last is 0x0F; frame_done in the cycle after its stop bit ends.
- Upstream stall mid-frame: s_tvalid low 100 cycles after pixel 2 -> line idle high, framer stays in DATA, remaining pixels follow with no new SYNC.
